// File: rtl/camera_frame_assembler.sv
// camera_frame_assembler: assembles raster pixels into ping-pong frame buffers
// and presents each complete frame over a four-phase Req/Ack handshake.
module camera_frame_assembler #(
  parameter int IMAGE_BITS = 8,
  parameter int MATRIX_N   = 10,
  parameter int MATRIX_M   = 10,
  parameter int FLAT_WIDE  = IMAGE_BITS * MATRIX_N * MATRIX_M
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [IMAGE_BITS-1:0] PixData,
  input  logic                  PixValid,
  input  logic                  FrameStart,
  output logic                  PixReady,
  input  logic                  AckIn,
  output logic                  ReqOut,
  output logic [FLAT_WIDE-1:0]  ImgMat,
  output logic                  FrameErr
);

  localparam int NPIX = MATRIX_N * MATRIX_M;
  localparam int IW   = $clog2(NPIX);
  localparam logic [IW-1:0] LAST = IW'(NPIX - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_REL
  } state_t;

  logic [1:0][FLAT_WIDE-1:0] buf_q, buf_d;
  logic [1:0]                full_q, full_d;
  logic [IW-1:0]             widx_q, widx_d;
  logic                      wsel_q, wsel_d;
  logic                      err_q, err_d;

  state_t                    state_q;
  logic                      rsel_q;
  logic                      req_q;
  logic [FLAT_WIDE-1:0]      img_q;

  logic accept;
  logic release_fire;
  logic pick;

  assign PixReady     = Reset && !full_q[wsel_q];
  assign accept       = PixValid && PixReady;
  assign release_fire = (state_q == S_REQ) && AckIn;
  // When both buffers are full the one about to be written next is the older.
  assign pick         = full_q[wsel_q] ? wsel_q : ~wsel_q;

  assign ReqOut   = req_q;
  assign ImgMat   = img_q;
  assign FrameErr = err_q;

  // Write side: pixel placement, resync on FrameStart, buffer completion.
  always_comb begin
    buf_d  = buf_q;
    full_d = full_q;
    widx_d = widx_q;
    wsel_d = wsel_q;
    err_d  = 1'b0;
    if (release_fire) begin
      full_d[rsel_q] = 1'b0;
    end
    if (accept) begin
      if (FrameStart) begin
        buf_d[wsel_q][IMAGE_BITS-1:0] = PixData;
        widx_d = IW'(1);
        err_d  = (widx_q != '0);
      end else if (widx_q != '0) begin
        for (int k = 1; k < NPIX; k++) begin
          if (widx_q == IW'(k)) begin
            buf_d[wsel_q][k*IMAGE_BITS +: IMAGE_BITS] = PixData;
          end
        end
        if (widx_q == LAST) begin
          full_d[wsel_q] = 1'b1;
          widx_d         = '0;
          wsel_d         = ~wsel_q;
        end else begin
          widx_d = widx_q + 1'b1;
        end
      end
    end
  end

  // Write-side state registers.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      buf_q  <= '0;
      full_q <= '0;
      widx_q <= '0;
      wsel_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      full_q <= full_d;
      widx_q <= widx_d;
      wsel_q <= wsel_d;
      err_q  <= err_d;
    end
  end

  // Output handshake FSM; ImgMat is captured so it holds after release.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      rsel_q  <= 1'b0;
      req_q   <= 1'b0;
      img_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (|full_q) begin
            rsel_q  <= pick;
            img_q   <= buf_q[pick];
            req_q   <= 1'b1;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (AckIn) begin
            req_q   <= 1'b0;
            state_q <= S_REL;
          end
        end
        S_REL: begin
          if (!AckIn) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
